// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and types.
package cpu_pkg;

   localparam int unsigned PC_W    = 4;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned SKIP_W  = 5;
   localparam int unsigned OP_HI   = 15;
   localparam int unsigned OP_LO   = 12;
   localparam logic [3:0]  HALT_OP = 4'b1111;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      STOP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/imem_word_mux.sv
// Combinational selection of one program word by address; shared with the debug read port.
module imem_word_mux #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned SEL_W  = 4
) (
   input  logic [DEPTH*WORD_W-1:0] words_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [WORD_W-1:0]       word_c
);

   logic [WORD_W-1:0] word_arr [DEPTH];

   // Unpack the flat ROM bus, word k at bits [WORD_W*k +: WORD_W].
   for (genvar k = 0; k < int'(DEPTH); k++) begin : g_unpack
      assign word_arr[k] = words_i[k*WORD_W +: WORD_W];
   end

   assign word_c = word_arr[sel_i];

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch stage: PC, fetch FSM, registered valid/ready output, issue counter.
// Optional feature macro: IMEM_FETCH_SKIP_NOP_EN (skip all-zero words, stop after 16 in a row).
module imem_fetch #(
   parameter int unsigned DEPTH   = cpu_pkg::DEPTH,
   parameter int unsigned PC_W    = cpu_pkg::PC_W,
   parameter logic [3:0]  HALT_OP = cpu_pkg::HALT_OP
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DEPTH*cpu_pkg::WORD_W-1:0]   prgm_words,
   input  logic                               out_ready,
   input  logic                               redir_valid,
   input  logic [PC_W-1:0]                    redir_pc,
   output logic                               out_valid,
   output logic [cpu_pkg::WORD_W-1:0]         instr,
   output logic [PC_W-1:0]                    instr_pc,
   output logic                               halted,
   output logic [cpu_pkg::CNT_W-1:0]          issue_cnt
);

   import cpu_pkg::*;

   fetch_state_t      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
   logic              halted_q, halted_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
`ifdef IMEM_FETCH_SKIP_NOP_EN
   localparam logic [SKIP_W-1:0] SKIP_LIMIT = SKIP_W'(DEPTH);
   logic [SKIP_W-1:0] skip_q, skip_d;
`endif

   logic [WORD_W-1:0] word_c;
   logic              accept_c;
   logic              halt_held_c;
   logic              load_slot_c;

   imem_word_mux #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .SEL_W  (PC_W)
   ) u_word_mux (
      .words_i (prgm_words),
      .sel_i   (pc_q),
      .word_c  (word_c)
   );

   assign accept_c    = out_valid_q && out_ready;
   assign halt_held_c = (instr_q[OP_HI:OP_LO] == HALT_OP);
   assign load_slot_c = (state_q == RUN) && (!out_valid_q || out_ready) && !redir_valid;

   // Next-state: acceptance first, then halt-stop, redirect, or a fetch slot.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      halted_d    = halted_q;
      issue_cnt_d = issue_cnt_q;
`ifdef IMEM_FETCH_SKIP_NOP_EN
      skip_d      = skip_q;
`endif

      if (accept_c) begin
         out_valid_d = 1'b0;
         if (issue_cnt_q != '1) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
         end
      end

      if (accept_c && halt_held_c) begin
         // Accepted halt is terminal; a same-cycle redirect loses.
         state_d  = STOP;
         halted_d = 1'b1;
      end else if (redir_valid && (state_q != STOP)) begin
         state_d     = RUN;
         pc_d        = redir_pc;
         out_valid_d = 1'b0;
`ifdef IMEM_FETCH_SKIP_NOP_EN
         skip_d      = '0;
`endif
      end else if (load_slot_c) begin
`ifdef IMEM_FETCH_SKIP_NOP_EN
         if (word_c == '0) begin
            // Zero word: advance PC without touching the output register.
            pc_d   = pc_q + PC_W'(1);
            skip_d = skip_q + SKIP_W'(1);
            if (skip_d == SKIP_LIMIT) begin
               state_d  = STOP;
               halted_d = 1'b1;
            end
         end else begin
            skip_d      = '0;
`else
         begin
`endif
            instr_d     = word_c;
            instr_pc_d  = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_W'(1);
            if (word_c[OP_HI:OP_LO] == HALT_OP) begin
               state_d = HOLD;
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pc_q        <= '0;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         instr_pc_q  <= '0;
         halted_q    <= 1'b0;
         issue_cnt_q <= '0;
`ifdef IMEM_FETCH_SKIP_NOP_EN
         skip_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         instr_pc_q  <= instr_pc_d;
         halted_q    <= halted_d;
         issue_cnt_q <= issue_cnt_d;
`ifdef IMEM_FETCH_SKIP_NOP_EN
         skip_q      <= skip_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign instr     = instr_q;
   assign instr_pc  = instr_pc_q;
   assign halted    = halted_q;
   assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios plus random traffic vs. a behavioural model.
module tb_imem_fetch;

   logic         clk;
   logic         rst_n;
   logic [255:0] prgm_words;
   logic         out_ready;
   logic         redir_valid;
   logic [3:0]   redir_pc;
   logic         out_valid;
   logic [15:0]  instr;
   logic [3:0]   instr_pc;
   logic         halted;
   logic [7:0]   issue_cnt;

   logic [15:0]  prog [16];

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model of what decode should see.
   bit          m_valid;
   logic [15:0] m_instr;
   int          m_ipc;
   int          m_pc;
   bit          m_halted;
   bit          m_stopped;
   bit          m_halt_pending;
   int          m_cnt;
   int          m_skips;

   imem_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prgm_words  (prgm_words),
      .out_ready   (out_ready),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .out_valid   (out_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .halted      (halted),
      .issue_cnt   (issue_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 16; k++) prgm_words[16*k +: 16] = prog[k];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_instr = 16'h0; m_ipc = 0; m_pc = 0;
      m_halted = 0; m_stopped = 0; m_halt_pending = 0; m_cnt = 0; m_skips = 0;
   endtask

   task automatic model_step(input bit rdy, input bit rv, input bit [3:0] rpc);
      bit acc;
      logic [15:0] w;
      acc = m_valid && rdy;
      if (acc) begin
         if (m_cnt < 255) m_cnt++;
         if (m_instr[15:12] == 4'hF) begin
            m_halted = 1; m_stopped = 1;
         end
      end
      if (m_stopped) begin
         if (acc) m_valid = 0;
         return;
      end
      if (rv) begin
         m_valid = 0; m_pc = rpc; m_halt_pending = 0; m_skips = 0;
         return;
      end
      if (m_halt_pending || (m_valid && !rdy)) begin
         if (acc) m_valid = 0;
         return;
      end
      w = prog[m_pc];
`ifdef IMEM_FETCH_SKIP_NOP_EN
      if (w == 16'h0) begin
         m_valid = 0;
         m_pc = (m_pc + 1) % 16;
         m_skips++;
         if (m_skips == 16) begin
            m_stopped = 1; m_halted = 1;
         end
         return;
      end
`endif
      m_instr = w; m_ipc = m_pc; m_valid = 1;
      m_pc = (m_pc + 1) % 16; m_skips = 0;
      m_halt_pending = (w[15:12] == 4'hF);
   endtask

   task automatic compare_all();
      check("out_valid", out_valid, m_valid);
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc[3:0]);
      check("halted", halted, m_halted);
      check("issue_cnt", issue_cnt, m_cnt);
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase of the next one.
   task automatic cyc(input bit rdy, input bit rv, input bit [3:0] rpc);
      out_ready = rdy; redir_valid = rv; redir_pc = rpc;
      model_step(rdy, rv, rpc);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_halted", halted, 0);
      check("rst_issue_cnt", issue_cnt, 0);
      model_reset();
      #2 rst_n = 1'b1;
   endtask

   task automatic rand_prog(input bit with_halt);
      for (int k = 0; k < 16; k++) begin
         prog[k] = 16'($urandom);
         if (!with_halt && prog[k][15:12] == 4'hF) prog[k][15:12] = 4'h7;
         if (with_halt && $urandom_range(0, 5) == 0) prog[k][15:12] = 4'hF;
         if ($urandom_range(0, 9) == 0) prog[k] = 16'h0;
      end
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 0; redir_valid = 0; redir_pc = 0;
      for (int k = 0; k < 16; k++) prog[k] = 16'h0;
      model_reset();
      #12;
      @(posedge clk); #1;
      check("init_out_valid", out_valid, 0);
      check("init_issue_cnt", issue_cnt, 0);

      // Basic run to a halt word.
      prog[0] = 16'h0000; prog[1] = 16'h1400; prog[2] = 16'h3802; prog[3] = 16'hF000;
      for (int k = 4; k < 16; k++) prog[k] = 16'h2000 | 16'(k);
      do_reset();
      cyc(1, 0, 0);
`ifndef IMEM_FETCH_SKIP_NOP_EN
      check("first_pc", instr_pc, 0);
      check("first_valid", out_valid, 1);
`endif
      repeat (6) cyc(1, 0, 0);
      check("halt_halted", halted, 1);
`ifdef IMEM_FETCH_SKIP_NOP_EN
      check("halt_cnt", issue_cnt, 3);
`else
      check("halt_cnt", issue_cnt, 4);
`endif
      check("halt_valid", out_valid, 0);

      // Stall, redirect, and cancelled halt.
      for (int k = 0; k < 16; k++) prog[k] = 16'h1000 | 16'(k);
      prog[5] = 16'hF005;
      do_reset();
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      repeat (3) begin
         cyc(0, 0, 0);
         check("stall_pc", instr_pc, 1);
         check("stall_instr", instr, 16'h1001);
      end
      cyc(1, 0, 0);  check("resume_pc", instr_pc, 2);
      cyc(1, 0, 0);
      cyc(1, 0, 0);  check("pc4", instr_pc, 4);
      cyc(0, 1, 9);  check("redir_bubble", out_valid, 0);
      cyc(0, 0, 0);  check("redir_pc9", instr_pc, 9);
      check("redir_cnt", issue_cnt, 4);
      cyc(0, 1, 5);
      cyc(0, 0, 0);  check("halt_held_pc", instr_pc, 5);
      cyc(0, 0, 0);
      cyc(0, 1, 2);  check("cancel_halted", halted, 0);
      cyc(1, 0, 0);  check("resume2_pc", instr_pc, 2);
      repeat (4) cyc(1, 0, 0);
      check("halt2_halted", halted, 1);
      check("halt2_cnt", issue_cnt, 8);
      cyc(1, 1, 0);  check("stop_ignore_redir", out_valid, 0);
      cyc(1, 0, 0);  check("stop_sticky", halted, 1);

      // Wrap and saturation.
      rand_prog(0);
      for (int k = 0; k < 16; k++) if (prog[k] == 16'h0) prog[k] = 16'h0101;
      do_reset();
      repeat (300) cyc(1, 0, 0);
      check("sat_cnt", issue_cnt, 255);

      // All-zero program.
      for (int k = 0; k < 16; k++) prog[k] = 16'h0;
      do_reset();
      repeat (16) cyc(1, 0, 0);
`ifdef IMEM_FETCH_SKIP_NOP_EN
      check("nop_halted", halted, 1);
      check("nop_cnt", issue_cnt, 0);
`else
      check("nop_halted", halted, 0);
      check("nop_cnt", issue_cnt, 15);
`endif
      repeat (4) cyc(1, 0, 0);

      // Mid-stream asynchronous reset at instr_pc 7.
      for (int k = 0; k < 16; k++) prog[k] = 16'h2200 | 16'(k);
      do_reset();
      repeat (8) cyc(1, 0, 0);
      check("pre_reset_pc", instr_pc, 7);
      do_reset();
      cyc(1, 0, 0);
      check("post_reset_pc", instr_pc, 0);
      check("post_reset_valid", out_valid, 1);

      // Random traffic.
      rand_prog(1);
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) prog[$urandom_range(0, 15)] = 16'($urandom);
         if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
            rand_prog(1);
            do_reset();
         end
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction fetch stage sitting directly downstream of the hard-wired 16-word program ROM and upstream of decode. Holds the 4-bit program counter, selects one of the 16 ROM words per cycle, and presents it to decode through a registered valid/ready interface. Handles redirects from execute, stops fetching at a halt opcode, and reports a saturating count of issued instructions.

## Interface
Parameters:
- `DEPTH`, 16: number of program words; must equal 2**`PC_W`.
- `PC_W`, 4: program-counter width.
- `HALT_OP`, 4'b1111: opcode in `instr[15:12]` that ends fetch.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `prgm_words`  in  256  ROM words; word k is `[16k+15:16k]`, k=0..15, k=0 is address 0.
- `out_ready`  in  1  decode accepts `instr` this cycle.
- `redir_valid`  in  1  execute requests a PC redirect.
- `redir_pc`  in  4  redirect target.
- `out_valid`  out  1  `instr`/`instr_pc` hold a valid instruction.
- `instr`  out  16  fetched instruction word.
- `instr_pc`  out  4  address of `instr`.
- `halted`  out  1  a halt instruction has been accepted by decode; sticky.
- `issue_cnt`  out  8  instructions accepted by decode, saturating at 255.

## Operation
- State machine with three states. RUN fetches. HOLD is entered when a `HALT_OP` word is loaded into the output register; in HOLD no further loads occur. STOP is entered when that halt word is accepted; STOP is terminal until reset.
- Load condition is RUN && (!`out_valid` || `out_ready`) && !`redir_valid`. On load: `instr` <= word[pc], `instr_pc` <= pc, `out_valid` <= 1, pc <= pc+1 mod 16. The PC wraps from 15 to 0.
- Acceptance is `out_valid` && `out_ready`. If acceptance occurs with no load in the same cycle, `out_valid` <= 0. Each acceptance increments `issue_cnt`, which saturates at 255.
- A redirect is taken when `redir_valid` is asserted in RUN or HOLD:
  - `out_valid` <= 0 (the held instruction is flushed and not counted).
  - pc <= `redir_pc`.
  - State returns to RUN.
  - An unaccepted halt word is cancelled by the redirect.
- In STOP, `redir_valid` is ignored.
- Simultaneous `redir_valid` and acceptance: the acceptance counts and `halted` may set, then the redirect applies. If that acceptance is the halt word, STOP wins and the redirect is ignored.
- `prgm_words` is sampled only at load time; changing it later does not alter a held `instr`.

## Timing
- Reset values: pc=0, state RUN, `out_valid`=0, `instr`=16'h0000, `instr_pc`=0, `halted`=0, `issue_cnt`=0.
- First `out_valid` appears on the first rising edge after `rst_n` deasserts, with `instr_pc`=0.
- With `out_ready` held high, throughput is one instruction per cycle.
- Redirect costs one bubble: `redir_valid` is seen at edge N, and `instr_pc`=`redir_pc` is valid after edge N+1.
- `halted` rises on the edge at which the halt word is accepted.
- Asserting `rst_n` low mid-operation immediately forces all reset values. No partial state survives.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `IMEM_FETCH_SKIP_NOP_EN` defined:
  - In RUN, a word equal to 16'h0000 is not loaded. The PC still advances, costing one cycle with `out_valid` unaffected.
  - A 5-bit consecutive-skip counter clears on any load or redirect.
  - When the counter reaches 16, the state enters STOP and `halted` asserts, so an all-zero program stops.
- Undefined: zero words are issued as normal instructions, and the skip counter is not built.

## Structure
- Shared package `cpu_pkg`:
  - `PC_W` and `DEPTH`.
  - `HALT_OP` and the opcode field slice constants `OP_HI`=15 and `OP_LO`=12.
  - `fetch_state_t` enum {RUN, HOLD, STOP}.
- One sub-module, `imem_word_mux`: purely combinational 16:1 selection of a 16-bit word from `prgm_words` by pc. It is reused by the debug read port.
- PC, state machine, output register and counters live in `imem_fetch`.

## Test plan
- Reset, then `out_ready`=1 with words 0..3 = 0000, 1400, 3802, F000: `instr_pc` sequences 0,1,2,3. Halt word 3 is accepted, then `halted`=1, `issue_cnt`=4, `out_valid`=0 thereafter.
- `out_ready` low for 3 cycles while word 1 is held: `instr` stays at word 1 and pc does not advance. `out_ready` high resumes at word 2 with no loss or duplication.
- `redir_valid` with `redir_pc`=9 while word 4 is held and not ready: word 4 is dropped and not counted. After one bubble, `instr_pc`=9.
- Halt at word 5 held but not accepted, then redirect to 2: `halted` stays 0 and fetch resumes at 2. A second halt accepted sets `halted`, and a later redirect is ignored.
- Program with no halt, 300 accepts: pc wraps 15→0 and `issue_cnt` saturates at 255. With `IMEM_FETCH_SKIP_NOP_EN` and all-zero words, `halted`=1 after 16 cycles with `issue_cnt`=0.
- `rst_n` pulsed low mid-stream at `instr_pc`=7: all outputs return to reset values asynchronously, and fetch restarts at 0.
